ball_physics: RTL and testbench

Frame-rate ball engine for the two-player pong game: advances the ball one step per 60 Hz frame and bounces it off the top/bottom walls and both paddles. It detects misses, keeps both scores, and sequences serve / point / game-over. It consumes the paddle position bus and publishes `b_x`/`b_y`, which the paddle block reads for CPU tracking and the draw pipeline reads for rendering.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/ball_collide.sv | 47 ++++
 rtl/ball_physics.sv | 215 +++++++++++++++++++++
 tb/tb_ball_physics.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared playfield geometry, direction encodings and the ball sequencing
// state type for the pong ball engine.
package pong_pkg;

  // Playfield geometry, held at 9 bits so sums such as paddle_x + s or
  // paddle_y + 20 never wrap during comparisons.
  localparam logic [8:0] TOP_Y      = 9'd31;
  localparam logic [8:0] BOT_Y      = 9'd119;
  localparam logic [8:0] MAX_X      = 9'd159;
  localparam logic [8:0] PADDLE_LEN = 9'd21;
  localparam logic [8:0] CTR_X      = 9'd80;
  localparam logic [8:0] CTR_Y      = 9'd75;

  // Direction bit encodings.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Top-level game states during which the draw pipeline owns the frame.
  localparam logic [2:0] TOP_DRAW  = 3'd4;
  localparam logic [2:0] TOP_ERASE = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2,
    OVER   = 2'd3
  } ball_state_t;

endpackage

// File: rtl/ball_collide.sv
// Combinational collision detector: flags wall bounces, paddle returns and
// misses for the current ball position, direction and step size.
module ball_collide
  import pong_pkg::*;
(
  input  logic [7:0] b_x,
  input  logic [6:0] b_y,
  input  logic       dx,
  input  logic       dy,
  input  logic [1:0] s,
  input  logic [7:0] paddle1_x,
  input  logic [6:0] paddle1_y,
  input  logic [7:0] paddle2_x,
  input  logic [6:0] paddle2_y,
  output logic       hit_top,
  output logic       hit_bot,
  output logic       hit_p1,
  output logic       hit_p2,
  output logic       miss_l,
  output logic       miss_r
);

  logic [8:0] bx9, by9, s9, p1x9, p1y9, p2x9, p2y9;
  logic       in_p1_rows, in_p2_rows;

  assign bx9  = {1'b0, b_x};
  assign by9  = {2'b00, b_y};
  assign s9   = {7'd0, s};
  assign p1x9 = {1'b0, paddle1_x};
  assign p1y9 = {2'b00, paddle1_y};
  assign p2x9 = {1'b0, paddle2_x};
  assign p2y9 = {2'b00, paddle2_y};

  assign in_p1_rows = (by9 >= p1y9) && (by9 <= p1y9 + PADDLE_LEN - 9'd1);
  assign in_p2_rows = (by9 >= p2y9) && (by9 <= p2y9 + PADDLE_LEN - 9'd1);

  assign hit_top = (dy == DIR_UP)   && (by9 < TOP_Y + s9);
  assign hit_bot = (dy == DIR_DOWN) && (by9 > BOT_Y - s9);

  // A return fires on the last step before the ball would cross the paddle face.
  assign hit_p1 = (dx == DIR_LEFT)  && (bx9 > p1x9) && (bx9 <= p1x9 + s9) && in_p1_rows;
  assign hit_p2 = (dx == DIR_RIGHT) && (bx9 < p2x9) && (bx9 + s9 >= p2x9) && in_p2_rows;

  assign miss_l = (dx == DIR_LEFT)  && (bx9 < s9);
  assign miss_r = (dx == DIR_RIGHT) && (bx9 > MAX_X - s9);

endmodule

// File: rtl/ball_physics.sv
// Frame-rate ball engine: moves the ball once per 60 Hz frame, bounces it off
// walls and paddles, scores misses and sequences serve / point / game over.
// Optional feature macro BALL_SPEEDUP_EN: the ball step rises from 1 to 2 on
// the 8th paddle return of a rally and drops back to 1 when a point is scored.
module ball_physics
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60
) (
  input  logic       sixtyhz_clk,
  input  logic       resetn,
  input  logic [2:0] state,
  input  logic       serve,
  input  logic [7:0] paddle1_x,
  input  logic [6:0] paddle1_y,
  input  logic [7:0] paddle2_x,
  input  logic [6:0] paddle2_y,
  output logic [7:0] b_x,
  output logic [6:0] b_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       p1_point,
  output logic       p2_point,
  output logic       game_over
);

  localparam int              DLY_W    = ($clog2(SERVE_DELAY) > 0) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SERVE_DELAY - 1);
  localparam logic [3:0]      WIN      = 4'(WIN_SCORE);

  ball_state_t      state_q, state_d;
  logic [7:0]       b_x_q, b_x_d;
  logic [6:0]       b_y_q, b_y_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic [3:0]       p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic             p1_point_q, p1_point_d, p2_point_q, p2_point_d;
  logic             game_over_q, game_over_d;
  logic [DLY_W-1:0] delay_q, delay_d;
  logic [1:0]       s;
  logic             frozen;
  logic             hit_top, hit_bot, hit_p1, hit_p2, miss_l, miss_r;

  assign frozen = (state == TOP_DRAW) || (state == TOP_ERASE);

  ball_collide u_collide (
    .b_x       (b_x_q),
    .b_y       (b_y_q),
    .dx        (dx_q),
    .dy        (dy_q),
    .s         (s),
    .paddle1_x (paddle1_x),
    .paddle1_y (paddle1_y),
    .paddle2_x (paddle2_x),
    .paddle2_y (paddle2_y),
    .hit_top   (hit_top),
    .hit_bot   (hit_bot),
    .hit_p1    (hit_p1),
    .hit_p2    (hit_p2),
    .miss_l    (miss_l),
    .miss_r    (miss_r)
  );

`ifdef BALL_SPEEDUP_EN
  logic [3:0] hits_q, hits_d;
  logic [1:0] s_q, s_d;
  logic       advance, paddle_hit, rally_end;

  assign advance    = !frozen && (state_q == MOVE);
  assign paddle_hit = advance && (hit_p1 || hit_p2);
  assign rally_end  = advance && !(hit_p1 || hit_p2) && (miss_l || miss_r);
  assign s          = s_q;

  // Count returns in the rally; the 8th one doubles the step, a point resets it.
  always_comb begin
    hits_d = hits_q;
    s_d    = s_q;
    if (rally_end) begin
      hits_d = 4'd0;
      s_d    = 2'd1;
    end else if (paddle_hit && (hits_q != 4'd8)) begin
      hits_d = hits_q + 4'd1;
      if (hits_q == 4'd7) s_d = 2'd2;
    end
  end

  // Speed-up registers.
  always_ff @(posedge sixtyhz_clk) begin
    if (!resetn) begin
      hits_q <= 4'd0;
      s_q    <= 2'd1;
    end else begin
      hits_q <= hits_d;
      s_q    <= s_d;
    end
  end
`else
  assign s = 2'd1;
`endif

  // Next-state and next-position logic for one frame.
  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d     = state_q;
    b_x_d       = b_x_q;
    b_y_d       = b_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    p1_point_d  = 1'b0;
    p2_point_d  = 1'b0;
    game_over_d = game_over_q;
    delay_d     = delay_q;

    if (!frozen) begin
      unique case (state_q)
        IDLE: begin
          b_x_d = CTR_X[7:0];
          b_y_d = CTR_Y[6:0];
          if (serve) state_d = MOVE;
        end

        MOVE: begin
          if (hit_top)               dy_d  = DIR_DOWN;
          else if (hit_bot)          dy_d  = DIR_UP;
          else if (dy_q == DIR_UP)   b_y_d = b_y_q - {5'd0, s};
          else                       b_y_d = b_y_q + {5'd0, s};

          if (hit_p1) begin
            dx_d = DIR_RIGHT;
          end else if (hit_p2) begin
            dx_d = DIR_LEFT;
          end else if (miss_l || miss_r) begin
            // Point: recentre, serve toward the conceding player, keep dy.
            b_x_d   = CTR_X[7:0];
            b_y_d   = CTR_Y[6:0];
            dy_d    = dy_q;
            delay_d = '0;
            if (miss_l) begin
              p2_score_d = p2_score_q + 4'd1;
              p2_point_d = 1'b1;
              dx_d       = DIR_LEFT;
            end else begin
              p1_score_d = p1_score_q + 4'd1;
              p1_point_d = 1'b1;
              dx_d       = DIR_RIGHT;
            end
            if ((p1_score_d == WIN) || (p2_score_d == WIN)) begin
              state_d     = OVER;
              game_over_d = 1'b1;
            end else begin
              state_d = SCORED;
            end
          end else if (dx_q == DIR_LEFT) begin
            b_x_d = b_x_q - {6'd0, s};
          end else begin
            b_x_d = b_x_q + {6'd0, s};
          end
        end

        SCORED: begin
          if (delay_q == DLY_LAST) state_d = MOVE;
          else                     delay_d = delay_q + 1'b1;
        end

        OVER: begin
          b_x_d = CTR_X[7:0];
          b_y_d = CTR_Y[6:0];
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Frame register bank with synchronous active-low reset.
  always_ff @(posedge sixtyhz_clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!resetn) begin
      state_q     <= IDLE;
      b_x_q       <= CTR_X[7:0];
      b_y_q       <= CTR_Y[6:0];
      dx_q        <= DIR_RIGHT;
      dy_q        <= DIR_DOWN;
      p1_score_q  <= 4'd0;
      p2_score_q  <= 4'd0;
      p1_point_q  <= 1'b0;
      p2_point_q  <= 1'b0;
      game_over_q <= 1'b0;
      delay_q     <= '0;
    end else begin
      state_q     <= state_d;
      b_x_q       <= b_x_d;
      b_y_q       <= b_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      p1_point_q  <= p1_point_d;
      p2_point_q  <= p2_point_d;
      game_over_q <= game_over_d;
      delay_q     <= delay_d;
    end
  end

  assign b_x       = b_x_q;
  assign b_y       = b_y_q;
  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign p1_point  = p1_point_q;
  assign p2_point  = p2_point_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: serve and first moves, wall and paddle
// bounces, a miss with the serve delay (including a freeze inside it),
// freeze mid-rally, reset mid-rally, a full game to WIN_SCORE and, when
// BALL_SPEEDUP_EN is defined, the step change on the 8th return.
module tb_ball_physics;

  logic       sixtyhz_clk = 1'b0;
  logic       resetn;
  logic [2:0] state;
  logic       serve;
  logic [7:0] paddle1_x, paddle2_x;
  logic [6:0] paddle1_y, paddle2_y;
  logic [7:0] b_x;
  logic [6:0] b_y;
  logic [3:0] p1_score, p2_score;
  logic       p1_point, p2_point, game_over;

  int assert_count = 0;
  int fail_count   = 0;

  ball_physics #(.WIN_SCORE(7), .SERVE_DELAY(60)) dut (
    .sixtyhz_clk (sixtyhz_clk),
    .resetn      (resetn),
    .state       (state),
    .serve       (serve),
    .paddle1_x   (paddle1_x),
    .paddle1_y   (paddle1_y),
    .paddle2_x   (paddle2_x),
    .paddle2_y   (paddle2_y),
    .b_x         (b_x),
    .b_y         (b_y),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .p1_point    (p1_point),
    .p2_point    (p2_point),
    .game_over   (game_over)
  );

  always #5 sixtyhz_clk = ~sixtyhz_clk;

  task automatic check(input string tag, input int got, input int exp);
    assert_count++;
    if (got != exp) begin
      fail_count++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, b_x, ex);
    check({tag, ".y"}, b_y, ey);
  endtask

  // Advance n frames; outputs are then sampled 1 ns after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sixtyhz_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    serve  = 1'b0;
    state  = 3'd0;
    step(1);
    resetn = 1'b1;
  endtask

  int cnt;

  initial begin
    resetn    = 1'b0;
    serve     = 1'b0;
    state     = 3'd0;
    paddle1_x = 8'd5;
    paddle1_y = 7'd100;
    paddle2_x = 8'd150;
    paddle2_y = 7'd85;
    step(2);

    // Reset values.
    check_pos("rst", 80, 75);
    check("rst.p1_score", p1_score, 0);
    check("rst.p2_score", p2_score, 0);
    check("rst.p1_point", p1_point, 0);
    check("rst.p2_point", p2_point, 0);
    check("rst.game_over", game_over, 0);

    // Rally A: k counts moving frames after the serve edge.
    resetn = 1'b1;
    step(3);
    check_pos("idle", 80, 75);
    serve = 1'b1;
    step(1);
    check_pos("serve_edge", 80, 75);
    step(1);  check_pos("k1", 81, 76);
    step(4);  check_pos("k5", 85, 80);
    step(39); check_pos("k44", 124, 119);
    step(1);  check_pos("bot_bounce", 125, 119);
    step(1);  check_pos("k46", 126, 118);
    step(23); check_pos("k69", 149, 95);
    step(1);  check_pos("p2_bounce", 149, 94);
    step(1);  check_pos("k71", 148, 93);
    step(62); check_pos("k133", 86, 31);
    step(1);  check_pos("top_bounce", 85, 31);
    step(1);  check_pos("k135", 84, 32);
    step(78); check_pos("k213", 6, 110);
    step(1);  check_pos("p1_bounce", 6, 111);
    step(1);  check_pos("k215", 7, 112);
    step(5);  check_pos("k220", 12, 117);

    // Freeze mid-rally.
    state = 3'd4;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_pos("freeze", 12, 117);
      check("freeze.p1_score", p1_score, 0);
    end
    state = 3'd0;
    step(1); check_pos("unfreeze", 13, 118);

    // Reset mid-rally.
    do_reset();
    check_pos("rst_mid", 80, 75);
    check("rst_mid.game_over", game_over, 0);

    // Rally B: left paddle out of the ball's rows, ball reaches x=0.
    paddle1_y = 7'd0;
    serve = 1'b1;
    step(1);
    step(219); check_pos("b_k219", 0, 116);
    step(1);
    check("miss.p2_point", p2_point, 1);
    check("miss.p2_score", p2_score, 1);
    check("miss.p1_score", p1_score, 0);
    check("miss.game_over", game_over, 0);
    check_pos("miss.centre", 80, 75);
    step(1);
    check("miss.p2_point_low", p2_point, 0);
    check_pos("delay1", 80, 75);
    for (int i = 0; i < 29; i++) begin
      step(1); check_pos("delay_a", 80, 75);
    end
    state = 3'd5;
    for (int i = 0; i < 5; i++) begin
      step(1); check_pos("delay_frz", 80, 75);
    end
    state = 3'd0;
    for (int i = 0; i < 30; i++) begin
      step(1); check_pos("delay_b", 80, 75);
    end
    step(1); check_pos("relaunch", 79, 76);
    check("relaunch.p2_score", p2_score, 1);

    // Game C: both paddles out of play, P1 wins every rally.
    do_reset();
    paddle1_y = 7'd0;
    paddle2_y = 7'd0;
    serve = 1'b1;
    step(1);
    for (int pt = 1; pt <= 7; pt++) begin
      cnt = 0;
      do begin
        step(1);
        cnt++;
      end while (!p1_point && cnt < 200);
      check("pt.frames", cnt, (pt == 1) ? 80 : 140);
      check("pt.p1_score", p1_score, pt);
      check("pt.p2_score", p2_score, 0);
      check("pt.game_over", game_over, (pt == 7) ? 1 : 0);
      check_pos("pt.centre", 80, 75);
    end
    step(1);
    check("over.p1_point_low", p1_point, 0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_pos("over", 80, 75);
      check("over.game_over", game_over, 1);
      check("over.p1_score", p1_score, 7);
    end
    do_reset();
    check("over_rst.game_over", game_over, 0);
    check("over_rst.p1_score", p1_score, 0);

`ifdef BALL_SPEEDUP_EN
    // Speed-up: paddles track the ball so every approach is returned.
    begin
      int hits;
      int prev_x;
      int frames;
      paddle1_x = 8'd5;
      paddle2_x = 8'd150;
      serve  = 1'b1;
      step(1);
      prev_x = b_x;
      hits   = 0;
      frames = 0;
      while (hits < 8 && frames < 2000) begin
        paddle1_y = (b_y >= 10) ? 7'(b_y - 10) : 7'd0;
        paddle2_y = paddle1_y;
        step(1);
        frames++;
        if (frames > 1 && b_x == prev_x) hits++;
        prev_x = b_x;
      end
      check("spd.hits", hits, 8);
      check("spd.hit8_x", b_x, 6);
      paddle1_y = (b_y >= 10) ? 7'(b_y - 10) : 7'd0;
      paddle2_y = paddle1_y;
      step(1); check("spd.x1", b_x, 8);
      step(1); check("spd.x2", b_x, 10);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
